// File: rtl/not_gate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : not_gate_arbiter
//  Purpose  : Four requesters share one registered WIDTH-bit inverter through
//             an IDLE/ISSUE/RESP handshake. Define NOT_GATE_ARB_RR_EN for
//             round-robin arbitration (default: fixed priority, req 0 first).
//  Revision : 1.0 - initial release
// ============================================================================
module not_gate_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [3:0]           req_i,
    input  logic [4*WIDTH-1:0]   data_i,
    output logic [3:0]           gnt_o,
    output logic                 busy_o,
    output logic                 res_valid_o,
    output logic [1:0]           res_id_o,
    output logic [WIDTH-1:0]     res_data_o,
    input  logic                 res_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_operand;
    logic [1:0]         r_winner;
    logic [1:0]         w_winner;
    logic               w_any;
    logic [WIDTH-1:0]   w_lane [4];

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            assign w_lane[k] = data_i[k*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_any  = |req_i;
    assign busy_o = (r_state != S_IDLE);

`ifdef NOT_GATE_ARB_RR_EN
    logic [1:0] r_ptr;
    logic [1:0] w_idx;
    logic       w_found;

    // Scan from the pointer upwards, wrapping modulo 4; first hit wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + i[1:0];
            if (!w_found && req_i[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end
`else
    always_comb begin
        w_winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req_i[i]) begin
                w_winner = i[1:0];
            end
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_operand   <= '0;
            r_winner    <= 2'd0;
            gnt_o       <= 4'b0000;
            res_valid_o <= 1'b0;
            res_id_o    <= 2'd0;
            res_data_o  <= '0;
`ifdef NOT_GATE_ARB_RR_EN
            r_ptr       <= 2'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_operand <= w_lane[w_winner];
                        r_winner  <= w_winner;
                        gnt_o     <= 4'b0001 << w_winner;
                        r_state   <= S_ISSUE;
`ifdef NOT_GATE_ARB_RR_EN
                        r_ptr     <= w_winner + 2'd1;
`endif
                    end
                end
                S_ISSUE: begin
                    res_data_o  <= ~r_operand;
                    res_id_o    <= r_winner;
                    res_valid_o <= 1'b1;
                    gnt_o       <= 4'b0000;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    // Result stays stable until the consumer takes it.
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    gnt_o       <= 4'b0000;
                    res_valid_o <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_not_gate_arbiter.sv
`default_nettype none
// Directed bench for not_gate_arbiter: vector table of single transactions
// plus hand-written backpressure, arbitration, reset and short-request cases.
module tb_not_gate_arbiter;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst_n_i;
    logic [3:0]         req_i;
    logic [4*WIDTH-1:0] data_i;
    logic [3:0]         gnt_o;
    logic               busy_o;
    logic               res_valid_o;
    logic [1:0]         res_id_o;
    logic [WIDTH-1:0]   res_data_o;
    logic               res_ready_i;

    int n_tests = 0;
    int n_fail  = 0;

    not_gate_arbiter #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .req_i       (req_i),
        .data_i      (data_i),
        .gnt_o       (gnt_o),
        .busy_o      (busy_o),
        .res_valid_o (res_valid_o),
        .res_id_o    (res_id_o),
        .res_data_o  (res_data_o),
        .res_ready_i (res_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [1:0]  id;
        logic [7:0]  res;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        req_i   = 4'b0000;
        step();
        step();
        rst_n_i = 1'b1;
    endtask

    // Entered in IDLE just after an edge; consumer always ready.
    task automatic do_txn(input logic [3:0] req, input logic [31:0] data,
                          input logic [1:0] id, input logic [7:0] res, input string tag);
        req_i       = req;
        data_i      = data;
        res_ready_i = 1'b1;
        step();
        req_i = 4'b0000;
        check({tag, "_gnt"}, {28'd0, gnt_o}, {28'd0, 4'b0001 << id});
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
        step();
        check({tag, "_valid"}, {31'd0, res_valid_o}, 32'd1);
        check({tag, "_id"}, {30'd0, res_id_o}, {30'd0, id});
        check({tag, "_data"}, {24'd0, res_data_o}, {24'd0, res});
        check({tag, "_gnt_clr"}, {28'd0, gnt_o}, 32'd0);
        step();
        check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
    endtask

    // Bounded wait for the next grant, then check it and its result.
    task automatic wait_grant(input logic [1:0] id, input logic [7:0] res, input string tag);
        int n = 0;
        while (gnt_o == 4'b0000 && n < 8) begin
            step();
            n++;
        end
        check({tag, "_gnt"}, {28'd0, gnt_o}, {28'd0, 4'b0001 << id});
        step();
        check({tag, "_valid"}, {31'd0, res_valid_o}, 32'd1);
        check({tag, "_id"}, {30'd0, res_id_o}, {30'd0, id});
        check({tag, "_data"}, {24'd0, res_data_o}, {24'd0, res});
    endtask

    initial begin
        // lanes packed {lane3, lane2, lane1, lane0}
        vecs[0] = '{4'b0100, 32'h00A5_0000, 2'd2, 8'h5A};
        vecs[1] = '{4'b0001, 32'h0000_0000, 2'd0, 8'hFF};
        vecs[2] = '{4'b1010, 32'h1122_3344, 2'd1, 8'hCC};
        vecs[3] = '{4'b1000, 32'hF000_0000, 2'd3, 8'h0F};
        vecs[4] = '{4'b1111, 32'h0FF0_55AA, 2'd0, 8'h55};
        vecs[5] = '{4'b1100, 32'h8001_0000, 2'd2, 8'hFE};
        vecs[6] = '{4'b0110, 32'h007E_8100, 2'd1, 8'h7E};
`ifdef NOT_GATE_ARB_RR_EN
        vecs[7] = '{4'b1001, 32'hC000_0003, 2'd3, 8'h3F};
`else
        vecs[7] = '{4'b1001, 32'hC000_0003, 2'd0, 8'hFC};
`endif

        rst_n_i     = 1'b0;
        req_i       = 4'b0000;
        data_i      = '0;
        res_ready_i = 1'b0;
        do_reset();
        check("rst_gnt",   {28'd0, gnt_o},       32'd0);
        check("rst_valid", {31'd0, res_valid_o}, 32'd0);
        check("rst_id",    {30'd0, res_id_o},    32'd0);
        check("rst_data",  {24'd0, res_data_o},  32'd0);
        check("rst_busy",  {31'd0, busy_o},      32'd0);

        for (int v = 0; v < 8; v++) begin
            do_txn(vecs[v].req, vecs[v].data, vecs[v].id, vecs[v].res, $sformatf("vec%0d", v));
        end

        // Backpressure with all requesters asserted, then arbitration order.
        do_reset();
        req_i       = 4'b1111;
        data_i      = 32'hF00F_FF00;
        res_ready_i = 1'b0;
        step();
        check("bp_gnt", {28'd0, gnt_o}, 32'd1);
        step();
        check("bp_valid0", {31'd0, res_valid_o}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("bp_valid_c%0d", c), {31'd0, res_valid_o}, 32'd1);
            check($sformatf("bp_id_c%0d", c),    {30'd0, res_id_o},    32'd0);
            check($sformatf("bp_data_c%0d", c),  {24'd0, res_data_o},  32'h0000_00FF);
            check($sformatf("bp_busy_c%0d", c),  {31'd0, busy_o},      32'd1);
            check($sformatf("bp_nognt_c%0d", c), {28'd0, gnt_o},       32'd0);
        end
        res_ready_i = 1'b1;
        step();
        check("bp_release_valid", {31'd0, res_valid_o}, 32'd0);
        check("bp_release_busy",  {31'd0, busy_o},      32'd0);
`ifdef NOT_GATE_ARB_RR_EN
        wait_grant(2'd1, 8'h00, "rr1");
        wait_grant(2'd2, 8'hF0, "rr2");
        wait_grant(2'd3, 8'h0F, "rr3");
        wait_grant(2'd0, 8'hFF, "rr0");
`else
        req_i = 4'b1010;
        wait_grant(2'd1, 8'h00, "fp_a");
        wait_grant(2'd1, 8'h00, "fp_b");
        wait_grant(2'd1, 8'h00, "fp_c");
`endif
        req_i = 4'b0000;
        step();

        // Reset during ISSUE aborts the transaction.
        req_i  = 4'b0100;
        data_i = 32'h0077_0000;
        step();
        check("mr_gnt", {28'd0, gnt_o}, 32'h4);
        req_i   = 4'b0000;
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        check("mr_gnt0",   {28'd0, gnt_o},       32'd0);
        check("mr_valid0", {31'd0, res_valid_o}, 32'd0);
        check("mr_data0",  {24'd0, res_data_o},  32'd0);
        check("mr_busy0",  {31'd0, busy_o},      32'd0);
        step();
        check("mr_noresult", {31'd0, res_valid_o}, 32'd0);
        do_txn(4'b0001, 32'h0000_003C, 2'd0, 8'hC3, "mr_fresh");

        // Pulse during RESP is ignored; a held request wins at first IDLE.
        res_ready_i = 1'b0;
        req_i       = 4'b0100;
        data_i      = 32'h00A5_0000;
        step();
        check("sr_gnt", {28'd0, gnt_o}, 32'h4);
        req_i = 4'b0000;
        step();
        req_i = 4'b0010;
        step();
        check("sr_pulse_nognt", {28'd0, gnt_o}, 32'd0);
        req_i = 4'b0000;
        step();
        req_i       = 4'b0001;
        data_i      = 32'h0000_005A;
        res_ready_i = 1'b1;
        step();
        check("sr_idle_gnt",  {28'd0, gnt_o},  32'd0);
        check("sr_idle_busy", {31'd0, busy_o}, 32'd0);
        step();
        check("sr_held_gnt", {28'd0, gnt_o}, 32'h1);
        req_i = 4'b0000;
        step();
        check("sr_id",   {30'd0, res_id_o},   32'd0);
        check("sr_data", {24'd0, res_data_o}, 32'h0000_00A5);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
